seg7_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 46 ++++
 rtl/seg7_if.sv | 31 +++
 rtl/seg7_decode.sv | 39 +++
 rtl/seg7_driver.sv | 126 ++++++++++++
 tb/tb_seg7_driver.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: glyph codes, segment
// patterns and the driver state encoding.
package seg7_pkg;

  // Glyph codes above the hex range
  localparam logic [4:0] GLYPH_BLANK      = 5'd16;
  localparam logic [4:0] GLYPH_MINUS      = 5'd17;
  localparam logic [4:0] GLYPH_UNDERSCORE = 5'd18;

  // Active-high segment patterns, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0          = 8'h3F;
  localparam logic [7:0] SEG_1          = 8'h06;
  localparam logic [7:0] SEG_2          = 8'h5B;
  localparam logic [7:0] SEG_3          = 8'h4F;
  localparam logic [7:0] SEG_4          = 8'h66;
  localparam logic [7:0] SEG_5          = 8'h6D;
  localparam logic [7:0] SEG_6          = 8'h7D;
  localparam logic [7:0] SEG_7          = 8'h07;
  localparam logic [7:0] SEG_8          = 8'h7F;
  localparam logic [7:0] SEG_9          = 8'h6F;
  localparam logic [7:0] SEG_A          = 8'h77;
  localparam logic [7:0] SEG_B          = 8'h7C;
  localparam logic [7:0] SEG_C          = 8'h39;
  localparam logic [7:0] SEG_D          = 8'h5E;
  localparam logic [7:0] SEG_E          = 8'h79;
  localparam logic [7:0] SEG_F          = 8'h71;
  localparam logic [7:0] SEG_MINUS      = 8'h40;
  localparam logic [7:0] SEG_UNDERSCORE = 8'h08;
  localparam logic [7:0] SEG_BLANK      = 8'h00;

  typedef enum logic {
    ST_BLANK,
    ST_ON
  } state_e;

  // One scanner sample: digit position and glyph code
  typedef struct packed {
    logic [2:0] pos;
    logic [4:0] code;
  } sample_t;

  // Position 7 never selects a digit, so the reset value is always replaced
  // by the first real scanner sample.
  localparam sample_t HELD_RESET = '{pos: 3'd7, code: GLYPH_BLANK};

endpackage

// File: rtl/seg7_if.sv
// Scanner-to-display bundle: scanner sample, display controls and the
// active-low segment/select lines.
interface seg7_if #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned PWM_BITS   = 4
);
  logic [2:0]            digit_pos;
  logic [4:0]            digit_cur;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [PWM_BITS-1:0]   brightness;
  logic [7:0]            seg_n;
  logic [NUM_DIGITS-1:0] sel_n;

  modport master (
    output digit_pos,
    output digit_cur,
    output dp_mask,
    output brightness,
    input  seg_n,
    input  sel_n
  );

  modport slave (
    input  digit_pos,
    input  digit_cur,
    input  dp_mask,
    input  brightness,
    output seg_n,
    output sel_n
  );
endinterface

// File: rtl/seg7_decode.sv
// Glyph code to active-high {g,f,e,d,c,b,a} segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  logic [7:0] pattern;

  // Lookup of the segment pattern; unused codes render blank
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      5'd0:             pattern = SEG_0;
      5'd1:             pattern = SEG_1;
      5'd2:             pattern = SEG_2;
      5'd3:             pattern = SEG_3;
      5'd4:             pattern = SEG_4;
      5'd5:             pattern = SEG_5;
      5'd6:             pattern = SEG_6;
      5'd7:             pattern = SEG_7;
      5'd8:             pattern = SEG_8;
      5'd9:             pattern = SEG_9;
      5'd10:            pattern = SEG_A;
      5'd11:            pattern = SEG_B;
      5'd12:            pattern = SEG_C;
      5'd13:            pattern = SEG_D;
      5'd14:            pattern = SEG_E;
      5'd15:            pattern = SEG_F;
      GLYPH_MINUS:      pattern = SEG_MINUS;
      GLYPH_UNDERSCORE: pattern = SEG_UNDERSCORE;
      default:          pattern = SEG_BLANK;
    endcase
  end

  assign seg = pattern[6:0];

endmodule

// File: rtl/seg7_driver.sv
// Common-anode 7-segment driver: captures the scanner sample across clock
// domains, blanks the display for a dead time on every digit change, and
// applies PWM brightness to the segment lines.
module seg7_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DEADTIME   = 64,
  parameter int unsigned PWM_BITS   = 4
) (
  input logic  clk,
  input logic  rst,
  seg7_if.slave bus
);

  localparam int unsigned DeadW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DeadW-1:0] DeadReload = DeadW'(DEADTIME - 1);

  sample_t               s1_q, s2_q, s3_q, held_q;
  sample_t               sample_in;
  state_e                state_q;
  logic [DeadW-1:0]      dead_q;
  logic [PWM_BITS-1:0]   pwm_q;
  logic [7:0]            seg_n_q;
  logic [NUM_DIGITS-1:0] sel_n_q;

  logic                  accept;
  logic [6:0]            glyph;
  logic                  dp_on;
  logic                  pwm_on;
  logic [NUM_DIGITS-1:0] sel_vec;
  logic [7:0]            lit_seg_n;
  logic [NUM_DIGITS-1:0] lit_sel_n;

  assign sample_in = {bus.digit_pos, bus.digit_cur};

  // Two-flop synchronizer plus a third stage used for the stability check.
  // Reset to the held reset value so nothing is accepted until real samples
  // have propagated through.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= HELD_RESET;
      s2_q <= HELD_RESET;
      s3_q <= HELD_RESET;
    end else begin
      s1_q <= sample_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // A sample is taken only when stable over two synchronized samples and new
  assign accept = (s2_q == s3_q) && (s2_q != held_q);

  seg7_decode u_decode (
    .code (held_q.code),
    .seg  (glyph)
  );

  // Digit select and decimal point for the held position
  always_comb begin
    sel_vec = '0;
    dp_on   = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (held_q.pos == 3'(i)) begin
        sel_vec[i] = 1'b1;
        dp_on      = bus.dp_mask[i];
      end
    end
  end

  // Free-running PWM phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 1'b1;
    end
  end

  // Full brightness is forced on since the counter can never exceed all ones
  assign pwm_on = (bus.brightness == '1) || (pwm_q < bus.brightness);

  // Lit outputs: select stays asserted through PWM-off cycles
  assign lit_seg_n = pwm_on ? ~{dp_on, glyph} : 8'hFF;
  assign lit_sel_n = ~sel_vec;

  // Dead-time FSM with registered outputs; an accept blanks on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      dead_q  <= DeadReload;
      held_q  <= HELD_RESET;
      seg_n_q <= 8'hFF;
      sel_n_q <= '1;
    end else if (accept) begin
      state_q <= ST_BLANK;
      dead_q  <= DeadReload;
      held_q  <= s2_q;
      seg_n_q <= 8'hFF;
      sel_n_q <= '1;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (dead_q == '0) begin
            state_q <= ST_ON;
            seg_n_q <= lit_seg_n;
            sel_n_q <= lit_sel_n;
          end else begin
            dead_q  <= dead_q - 1'b1;
            seg_n_q <= 8'hFF;
            sel_n_q <= '1;
          end
        end
        ST_ON: begin
          seg_n_q <= lit_seg_n;
          sel_n_q <= lit_sel_n;
        end
      endcase
    end
  end

  assign bus.seg_n = seg_n_q;
  assign bus.sel_n = sel_n_q;

endmodule

// File: tb/tb_seg7_driver.sv
// Bench for seg7_driver: directed scenarios plus randomized scanning, every
// cycle compared against a behavioural model of the display.
module tb_seg7_driver;

  localparam int NumDigits = 6;
  localparam int DeadTime  = 64;
  localparam int PwmBits   = 4;
  localparam int Latency   = 4 + DeadTime;

  logic clk = 1'b0;
  logic rst;

  seg7_if #(.NUM_DIGITS(NumDigits), .PWM_BITS(PwmBits)) bus ();

  seg7_driver #(
    .NUM_DIGITS (NumDigits),
    .DEADTIME   (DeadTime),
    .PWM_BITS   (PwmBits)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference font {g,f,e,d,c,b,a}
  logic [6:0] hex_font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: last three pin samples (oldest first), displayed sample,
  // edges since it was taken, edges since reset.
  logic [7:0] hist [$] = '{8'hF0, 8'hF0, 8'hF0};
  logic [7:0] m_held   = 8'hF0;
  int         m_since  = 0;
  int         m_edges  = 0;
  logic [7:0] exp_seg  = 8'hFF;
  logic [5:0] exp_sel  = 6'h3F;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock edge: advance the model with the pre-edge inputs, then compare
  task automatic tick();
    logic [7:0] pin;
    logic [3:0] bri;
    logic [7:0] dpw;
    logic [2:0] pos;
    logic [4:0] code;
    logic [6:0] font;
    logic       on;
    pin = {bus.digit_pos, bus.digit_cur};
    bri = bus.brightness;
    dpw = {2'b00, bus.dp_mask};
    @(posedge clk);
    if (rst) begin
      hist    = '{8'hF0, 8'hF0, 8'hF0};
      m_held  = 8'hF0;
      m_since = 0;
      m_edges = 0;
      exp_seg = 8'hFF;
      exp_sel = 6'h3F;
    end else begin
      // A value is taken once seen twice in a row two samples behind the pins
      if (hist[1] == hist[0] && hist[1] != m_held) begin
        m_held  = hist[1];
        m_since = 0;
      end else if (m_since < 100000) begin
        m_since++;
      end
      void'(hist.pop_front());
      hist.push_back(pin);
      m_edges++;
      if (m_since < DeadTime) begin
        exp_seg = 8'hFF;
        exp_sel = 6'h3F;
      end else begin
        pos  = m_held[7:5];
        code = m_held[4:0];
        if (code < 16)       font = hex_font[code[3:0]];
        else if (code == 17) font = 7'h40;
        else if (code == 18) font = 7'h08;
        else                 font = 7'h00;
        on      = (bri == 4'hF) || (((m_edges - 1) % 16) < int'(bri));
        exp_sel = (pos < 6) ? ~(6'b1 << pos) : 6'h3F;
        exp_seg = on ? ~{dpw[pos], font} : 8'hFF;
      end
    end
    #1;
    check("seg_n", int'(bus.seg_n), int'(exp_seg));
    check("sel_n", int'(bus.sel_n), int'(exp_sel));
  endtask

  task automatic set_digit(input int pos, input int code);
    bus.digit_pos = 3'(pos);
    bus.digit_cur = 5'(code);
  endtask

  // Tick until the outputs show the target, counting ticks and all-off cycles
  task automatic wait_out(input logic [5:0] sel, input logic [7:0] seg,
                          output int ticks, output int blanks);
    ticks  = 0;
    blanks = 0;
    do begin
      tick();
      ticks++;
      if (bus.sel_n == 6'h3F && bus.seg_n == 8'hFF) blanks++;
    end while ((bus.sel_n != sel || bus.seg_n != seg) && ticks < 400);
  endtask

  logic [5:0] scan_sel [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [7:0] scan_seg [6] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};

  initial begin
    int t, b, t2, b2, lit;

    // Reset with a pending sample
    rst            = 1'b1;
    bus.dp_mask    = '0;
    bus.brightness = 4'hF;
    set_digit(2, 5);
    repeat (3) begin
      tick();
      check("rst_seg", int'(bus.seg_n), 'hFF);
      check("rst_sel", int'(bus.sel_n), 'h3F);
    end
    rst = 1'b0;
    wait_out(6'h3B, 8'h92, t, b);
    check("rst_latency", t, Latency);
    check("rst_blanks", b, Latency - 1);

    // Scan sequence
    for (int p = 0; p < 6; p++) begin
      set_digit(p, p + 1);
      wait_out(scan_sel[p], scan_seg[p], t, b);
      check("scan_latency", t, Latency);
      check("scan_dead", b, DeadTime);
      check("scan_sel", int'(bus.sel_n), int'(scan_sel[p]));
      repeat (500 - t) tick();
    end

    // Single-cycle glitch is ignored, a held change is taken
    set_digit(0, 0);
    wait_out(6'h3E, 8'hC0, t, b);
    repeat (10) tick();
    bus.digit_cur = 5'd8;
    tick();
    bus.digit_cur = 5'd0;
    b = 0;
    repeat (80) begin
      tick();
      if (bus.sel_n == 6'h3F) b++;
    end
    check("glitch_blanks", b, 0);
    set_digit(0, 8);
    wait_out(6'h3E, 8'h80, t, b);
    check("held_change_latency", t, Latency);

    // PWM duty
    bus.brightness = 4'd4;
    lit = 0;
    repeat (64) begin
      tick();
      if (bus.seg_n != 8'hFF) lit++;
    end
    check("pwm_4", lit, 16);
    bus.brightness = 4'd0;
    lit = 0;
    repeat (64) begin
      tick();
      if (bus.seg_n != 8'hFF) lit++;
      if (bus.sel_n != 6'h3E) lit += 100;
    end
    check("pwm_0", lit, 0);
    bus.brightness = 4'hF;
    lit = 0;
    repeat (64) begin
      tick();
      if (bus.seg_n != 8'hFF) lit++;
    end
    check("pwm_15", lit, 64);

    // Boundaries
    set_digit(6, 3);
    repeat (100) tick();
    check("pos6_sel", int'(bus.sel_n), 'h3F);
    set_digit(7, 3);
    repeat (100) tick();
    check("pos7_sel", int'(bus.sel_n), 'h3F);
    set_digit(1, 20);
    repeat (100) tick();
    check("code20_seg", int'(bus.seg_n), 'hFF);
    check("code20_sel", int'(bus.sel_n), 'h3D);
    bus.dp_mask = 6'b000100;
    set_digit(2, 16);
    repeat (100) tick();
    check("dp_only_seg", int'(bus.seg_n), 'h7F);
    bus.dp_mask = '0;
    set_digit(2, 5);
    wait_out(6'h3B, 8'h92, t, b);
    set_digit(3, 3);
    b = 0;
    repeat (30) begin
      tick();
      if (bus.sel_n == 6'h3F && bus.seg_n == 8'hFF) b++;
    end
    set_digit(4, 4);
    wait_out(6'h2F, 8'h99, t2, b2);
    check("restart_dead", b + b2, 30 + DeadTime);

    // Reset while lit
    set_digit(3, 3);
    wait_out(6'h37, 8'hB0, t, b);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("midon_rst_seg", int'(bus.seg_n), 'hFF);
    check("midon_rst_sel", int'(bus.sel_n), 'h3F);
    repeat (2) tick();
    rst = 1'b0;
    wait_out(6'h37, 8'hB0, t, b);
    check("midon_relatency", t, Latency);

    // Randomized scanning against the model
    for (int i = 0; i < 60; i++) begin
      set_digit($urandom_range(7, 0), $urandom_range(31, 0));
      if ($urandom_range(3, 0) == 0) bus.brightness = 4'($urandom_range(15, 0));
      if ($urandom_range(3, 0) == 0) bus.dp_mask = 6'($urandom_range(63, 0));
      if ($urandom_range(2, 0) == 0) repeat ($urandom_range(3, 1)) tick();
      else repeat ($urandom_range(150, 1)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
